// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg : opcodes, ALU class codes, FSM states and control-word helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Class codes shared with the ALU control stage.
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ADDI  = 3'b011;
    localparam logic [2:0] ALU_ANDI  = 3'b100;
    localparam logic [2:0] ALU_ORI   = 3'b101;
    localparam logic [2:0] ALU_SLTI  = 3'b110;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_I_EXEC   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_LW      = 3'd0,
        CLS_SW      = 3'd1,
        CLS_RTYPE   = 3'd2,
        CLS_ITYPE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    // Moore control word for a state; FETCH and MEM_WR entries are the
    // mem_ready=1 values and get gated at the top level.
    function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] imm_alu_op);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            ST_DECODE: c.alu_src_b = 2'b11;
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_RTYPE;
            end
            ST_R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = imm_alu_op;
            end
            ST_I_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
                c.alu_op     = imm_alu_op;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/opcode_class_decode.sv
// ---------------------------------------------------------------------------
// opcode_class_decode : opcode -> instruction class and I-type ALU class code
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module opcode_class_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode_i,
    output instr_class_t iclass_o,
    output logic [2:0]   imm_alu_op_o
);

    always_comb begin
        iclass_o     = CLS_ILLEGAL;
        imm_alu_op_o = ALU_ADD;
        case (opcode_i)
            OP_LW:    iclass_o = CLS_LW;
            OP_SW:    iclass_o = CLS_SW;
            OP_RTYPE: iclass_o = CLS_RTYPE;
            OP_BEQ:   iclass_o = CLS_BRANCH;
            OP_J:     iclass_o = CLS_JUMP;
            OP_ADDI: begin
                iclass_o     = CLS_ITYPE;
                imm_alu_op_o = ALU_ADDI;
            end
            OP_ANDI: begin
                iclass_o     = CLS_ITYPE;
                imm_alu_op_o = ALU_ANDI;
            end
            OP_ORI: begin
                iclass_o     = CLS_ITYPE;
                imm_alu_op_o = ALU_ORI;
            end
            OP_SLTI: begin
                iclass_o     = CLS_ITYPE;
                imm_alu_op_o = ALU_SLTI;
            end
            default: begin
                iclass_o     = CLS_ILLEGAL;
                imm_alu_op_o = ALU_ADD;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control : main control FSM of the multicycle MIPS datapath.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (sticky TRAP on unknown opcode).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       i_or_d_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_source_o,
    output logic [2:0] alu_op_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    if (MEM_WAIT_MAX != 0) begin : g_mem_wait_check
        $error("MEM_WAIT_MAX is reserved and must be 0");
    end

    state_t       state_q, state_d;
    ctrl_t        ctrl_q;
    ctrl_t        w_ctrl;
    instr_class_t w_class;
    logic [2:0]   w_imm_alu_op;
    logic         w_fetch_wait;
    logic         w_wr_wait;
    logic         w_nop_done;

    opcode_class_decode u_decode (
        .opcode_i     (opcode_i),
        .iclass_o     (w_class),
        .imm_alu_op_o (w_imm_alu_op)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (mem_ready_i) state_d = ST_DECODE;
            ST_DECODE: begin
                case (w_class)
                    CLS_LW, CLS_SW: state_d = ST_MEM_ADDR;
                    CLS_RTYPE:      state_d = ST_R_EXEC;
                    CLS_ITYPE:      state_d = ST_I_EXEC;
                    CLS_BRANCH:     state_d = ST_BRANCH;
                    CLS_JUMP:       state_d = ST_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:        state_d = ST_TRAP;
`else
                    default:        state_d = ST_FETCH;
`endif
                endcase
            end
            ST_MEM_ADDR: state_d = (w_class == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready_i) state_d = ST_MEM_WB;
            ST_MEM_WR:   if (mem_ready_i) state_d = ST_FETCH;
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_I_EXEC:   state_d = ST_I_WB;
`ifdef MC_ILLEGAL_TRAP_EN
            ST_TRAP:     state_d = ST_TRAP;
`endif
            default:     state_d = ST_FETCH;
        endcase
    end

    // The control word is registered alongside the state; I_WB keeps the
    // class code chosen when I_EXEC was entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ctrl_q  <= state_ctrl(ST_FETCH, ALU_ADD);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d,
                                  (state_d == ST_I_WB) ? ctrl_q.alu_op : w_imm_alu_op);
        end
    end

    assign w_fetch_wait = (state_q == ST_FETCH)  && !mem_ready_i;
    assign w_wr_wait    = (state_q == ST_MEM_WR) && !mem_ready_i;
    assign w_ctrl       = rst ? '0 : ctrl_q;

`ifdef MC_ILLEGAL_TRAP_EN
    assign w_nop_done = 1'b0;
    assign illegal_o  = !rst && (state_q == ST_TRAP);
`else
    // An unknown opcode retires from DECODE as a two-cycle nop.
    assign w_nop_done = !rst && (state_q == ST_DECODE) && (w_class == CLS_ILLEGAL);
    assign illegal_o  = 1'b0;
`endif

    assign pc_write_o      = w_ctrl.pc_write && !w_fetch_wait;
    assign ir_write_o      = w_ctrl.ir_write && !w_fetch_wait;
    assign instr_done_o    = (w_ctrl.instr_done && !w_wr_wait) || w_nop_done;
    assign pc_write_cond_o = w_ctrl.pc_write_cond;
    assign reg_write_o     = w_ctrl.reg_write;
    assign mem_read_o      = w_ctrl.mem_read;
    assign mem_write_o     = w_ctrl.mem_write;
    assign i_or_d_o        = w_ctrl.i_or_d;
    assign mem_to_reg_o    = w_ctrl.mem_to_reg;
    assign reg_dst_o       = w_ctrl.reg_dst;
    assign alu_src_a_o     = w_ctrl.alu_src_a;
    assign alu_src_b_o     = w_ctrl.alu_src_b;
    assign pc_source_o     = w_ctrl.pc_source;
    assign alu_op_o        = w_ctrl.alu_op;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control : directed per-cycle vectors for multicycle_control.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b000000;
    logic       mem_ready = 1'b1;

    logic       pc_write, pc_write_cond, ir_write, reg_write;
    logic       mem_read, mem_write, i_or_d, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       instr_done, illegal;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT_MAX(0)) dut (
        .clk             (clk),
        .rst             (rst),
        .opcode_i        (opcode),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .ir_write_o      (ir_write),
        .reg_write_o     (reg_write),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .i_or_d_o        (i_or_d),
        .mem_to_reg_o    (mem_to_reg),
        .reg_dst_o       (reg_dst),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .pc_source_o     (pc_source),
        .alu_op_o        (alu_op),
        .instr_done_o    (instr_done),
        .illegal_o       (illegal)
    );

    // Output vector bit map used by the expected constants below.
    wire [18:0] w_obs = {pc_write, pc_write_cond, ir_write, reg_write, mem_read,
                         mem_write, i_or_d, mem_to_reg, reg_dst, alu_src_a,
                         alu_src_b, pc_source, alu_op, instr_done, illegal};

    localparam logic [18:0] B_PCW  = 19'h1 << 18;
    localparam logic [18:0] B_PWC  = 19'h1 << 17;
    localparam logic [18:0] B_IRW  = 19'h1 << 16;
    localparam logic [18:0] B_RW   = 19'h1 << 15;
    localparam logic [18:0] B_MRD  = 19'h1 << 14;
    localparam logic [18:0] B_MWR  = 19'h1 << 13;
    localparam logic [18:0] B_IOD  = 19'h1 << 12;
    localparam logic [18:0] B_M2R  = 19'h1 << 11;
    localparam logic [18:0] B_RDST = 19'h1 << 10;
    localparam logic [18:0] B_ASA  = 19'h1 << 9;
    localparam logic [18:0] B_DONE = 19'h1 << 1;
    localparam logic [18:0] B_ILL  = 19'h1;

    function automatic logic [18:0] sb(input int v);  return 19'(v) << 7; endfunction
    function automatic logic [18:0] ps(input int v);  return 19'(v) << 5; endfunction
    function automatic logic [18:0] aop(input int v); return 19'(v) << 2; endfunction

    logic [18:0] e_fetch_rdy, e_fetch_wait, e_decode, e_maddr, e_mrd, e_mwb;
    logic [18:0] e_mwr_wait, e_mwr_rdy, e_rexec, e_rwb, e_br, e_jmp;

    task automatic check_val(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, sample mid-cycle.
    task automatic cyc(input string tag, input logic r, input logic [5:0] op,
                       input logic rdy, input logic [18:0] exp);
        @(posedge clk);
        #1;
        rst       = r;
        opcode    = op;
        mem_ready = rdy;
        #3;
        check_val(tag, w_obs, exp);
    endtask

    initial begin
        e_fetch_rdy  = B_PCW | B_IRW | B_MRD | sb(1);
        e_fetch_wait = B_MRD | sb(1);
        e_decode     = sb(3);
        e_maddr      = B_ASA | sb(2);
        e_mrd        = B_MRD | B_IOD;
        e_mwb        = B_RW | B_M2R | B_DONE;
        e_mwr_wait   = B_MWR | B_IOD;
        e_mwr_rdy    = B_MWR | B_IOD | B_DONE;
        e_rexec      = B_ASA | aop(2);
        e_rwb        = B_RW | B_RDST | B_DONE;
        e_br         = B_ASA | aop(1) | B_PWC | ps(1) | B_DONE;
        e_jmp        = B_PCW | ps(2) | B_DONE;

        cyc("reset0", 1'b1, 6'b000000, 1'b1, 19'h0);
        cyc("reset1", 1'b1, 6'b100011, 1'b1, 19'h0);

        // lw with two MEM_RD wait cycles: 7 cycles
        cyc("lw_fetch",  1'b0, 6'b100011, 1'b1, e_fetch_rdy);
        cyc("lw_decode", 1'b0, 6'b100011, 1'b1, e_decode);
        cyc("lw_maddr",  1'b0, 6'b100011, 1'b1, e_maddr);
        cyc("lw_wait1",  1'b0, 6'b100011, 1'b0, e_mrd);
        cyc("lw_wait2",  1'b0, 6'b100011, 1'b0, e_mrd);
        cyc("lw_rd",     1'b0, 6'b100011, 1'b1, e_mrd);
        cyc("lw_wb",     1'b0, 6'b100011, 1'b1, e_mwb);

        // R-type, ori, slti
        cyc("r_fetch",   1'b0, 6'b000000, 1'b1, e_fetch_rdy);
        cyc("r_decode",  1'b0, 6'b000000, 1'b1, e_decode);
        cyc("r_exec",    1'b0, 6'b000000, 1'b1, e_rexec);
        cyc("r_wb",      1'b0, 6'b000000, 1'b1, e_rwb);
        cyc("ori_fetch", 1'b0, 6'b001101, 1'b1, e_fetch_rdy);
        cyc("ori_dec",   1'b0, 6'b001101, 1'b1, e_decode);
        cyc("ori_exec",  1'b0, 6'b001101, 1'b1, B_ASA | sb(2) | aop(5));
        cyc("ori_wb",    1'b0, 6'b001101, 1'b1, B_RW | B_DONE | aop(5));
        cyc("slti_fetch",1'b0, 6'b001010, 1'b1, e_fetch_rdy);
        cyc("slti_dec",  1'b0, 6'b001010, 1'b1, e_decode);
        cyc("slti_exec", 1'b0, 6'b001010, 1'b1, B_ASA | sb(2) | aop(6));
        cyc("slti_wb",   1'b0, 6'b001010, 1'b1, B_RW | B_DONE | aop(6));

        // beq and j: 3 cycles each
        cyc("beq_fetch", 1'b0, 6'b000100, 1'b1, e_fetch_rdy);
        cyc("beq_dec",   1'b0, 6'b000100, 1'b1, e_decode);
        cyc("beq_exec",  1'b0, 6'b000100, 1'b1, e_br);
        cyc("j_fetch",   1'b0, 6'b000010, 1'b1, e_fetch_rdy);
        cyc("j_dec",     1'b0, 6'b000010, 1'b1, e_decode);
        cyc("j_exec",    1'b0, 6'b000010, 1'b1, e_jmp);

        // sw with one FETCH wait and one MEM_WR wait
        cyc("sw_fwait",  1'b0, 6'b101011, 1'b0, e_fetch_wait);
        cyc("sw_fetch",  1'b0, 6'b101011, 1'b1, e_fetch_rdy);
        cyc("sw_dec",    1'b0, 6'b101011, 1'b1, e_decode);
        cyc("sw_maddr",  1'b0, 6'b101011, 1'b1, e_maddr);
        cyc("sw_wwait",  1'b0, 6'b101011, 1'b0, e_mwr_wait);
        cyc("sw_wr",     1'b0, 6'b101011, 1'b1, e_mwr_rdy);

        // addi and andi
        cyc("addi_fetch",1'b0, 6'b001000, 1'b1, e_fetch_rdy);
        cyc("addi_dec",  1'b0, 6'b001000, 1'b1, e_decode);
        cyc("addi_exec", 1'b0, 6'b001000, 1'b1, B_ASA | sb(2) | aop(3));
        cyc("addi_wb",   1'b0, 6'b001000, 1'b1, B_RW | B_DONE | aop(3));
        cyc("andi_fetch",1'b0, 6'b001100, 1'b1, e_fetch_rdy);
        cyc("andi_dec",  1'b0, 6'b001100, 1'b1, e_decode);
        cyc("andi_exec", 1'b0, 6'b001100, 1'b1, B_ASA | sb(2) | aop(4));
        cyc("andi_wb",   1'b0, 6'b001100, 1'b1, B_RW | B_DONE | aop(4));

        // Illegal opcode 111111
        cyc("ill_fetch", 1'b0, 6'b111111, 1'b1, e_fetch_rdy);
`ifdef MC_ILLEGAL_TRAP_EN
        cyc("ill_dec",   1'b0, 6'b111111, 1'b1, e_decode);
        cyc("ill_trap0", 1'b0, 6'b111111, 1'b1, B_ILL);
        cyc("ill_trap1", 1'b0, 6'b100011, 1'b1, B_ILL);
        cyc("ill_trap2", 1'b0, 6'b000000, 1'b0, B_ILL);
        cyc("ill_rst",   1'b1, 6'b000000, 1'b1, 19'h0);
`else
        cyc("ill_dec",   1'b0, 6'b111111, 1'b1, e_decode | B_DONE);
`endif
        cyc("post_ill_fetch", 1'b0, 6'b000100, 1'b1, e_fetch_rdy);
        cyc("post_ill_dec",   1'b0, 6'b000100, 1'b1, e_decode);
        cyc("post_ill_br",    1'b0, 6'b000100, 1'b1, e_br);

        // Reset during a MEM_WR wait aborts the store
        cyc("swr_fetch", 1'b0, 6'b101011, 1'b1, e_fetch_rdy);
        cyc("swr_dec",   1'b0, 6'b101011, 1'b1, e_decode);
        cyc("swr_maddr", 1'b0, 6'b101011, 1'b1, e_maddr);
        cyc("swr_wait",  1'b0, 6'b101011, 1'b0, e_mwr_wait);
        cyc("swr_rst",   1'b1, 6'b101011, 1'b0, 19'h0);
        cyc("swr_refetch_wait", 1'b0, 6'b000000, 1'b0, e_fetch_wait);
        cyc("swr_refetch", 1'b0, 6'b000000, 1'b1, e_fetch_rdy);
        cyc("swr_r_dec",   1'b0, 6'b000000, 1'b1, e_decode);
        cyc("swr_r_exec",  1'b0, 6'b000000, 1'b1, e_rexec);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
